// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up an rPLL: pulses its RESET, waits for LOCK (with a per-attempt
// timeout and a bounded number of retries), requires LOCK to stay high for a
// qualification window, then releases the reset of the PLL-clocked logic.
// Lock loss while running re-runs the sequence and sets a sticky flag.
//
// Ports
//   clk_i        free-running board clock, all logic on its rising edge
//   rst_n_i      synchronous active-low reset
//   pll_lock_i   rPLL LOCK, asynchronous to clk_i (2-flop synchronized)
//   restart_i    single-cycle request to re-run the whole sequence
//   pll_reset_o  rPLL RESET, active-high (PLL_RST and FAIL)
//   sys_rst_n_o  active-low reset for PLL-clocked logic (released in RUN)
//   ready_o      high only in RUN
//   fail_o       high only in FAIL
//   lock_lost_o  sticky: lock dropped while in RUN
//   retry_cnt_o  timed-out attempts since last RUN entry / restart
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_reset_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_cnt_o
);

  localparam int unsigned CNT_MAX_AB =
    (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX =
    (CNT_MAX_AB > LOCK_STABLE_CYCLES) ? CNT_MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic [3:0]       retry_cnt, retry_nxt;
  logic             lock_lost, lost_nxt;
  logic             lock_meta, lock_sync;

  // Two-flop synchronizer for the asynchronous LOCK input.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost;
    if (restart_i) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
      lost_nxt  = 1'b0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (lock_sync) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_nxt = FAIL;
            end else begin
              state_nxt = PLL_RST;
              retry_nxt = retry_cnt + 4'd1;
            end
          end
        end
        STABLE: begin
          if (!lock_sync) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state_nxt = PLL_RST;
            lost_nxt  = 1'b1;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = PLL_RST;
        end
      endcase
    end
  end

  // Restart must also clear the counter when it arrives in PLL_RST, where
  // the state itself does not change.
  assign cnt_clr = restart_i || (state_nxt != state);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        // Saturate so the idle count in RUN/FAIL can never wrap.
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pll_reset_o = (state == PLL_RST) || (state == FAIL);
    sys_rst_n_o = (state == RUN);
    ready_o     = (state == RUN);
    fail_o      = (state == FAIL);
    lock_lost_o = lock_lost;
    retry_cnt_o = retry_cnt;
  end

endmodule
